// File: rtl/lsu_bus_if.sv
// lsu_bus_if: load/store unit between the core datapath and a handshaked
// data-memory bus. One legal load or store becomes one word-aligned bus
// transaction with byte strobes. Load data is sign- or zero-extended back to
// the core. The core is stalled until the bus acknowledges, the access is
// rejected, or a timeout fires.
//
// Ports
//   clk, rst        clock, asynchronous active-low reset
//   mem_rd, mem_wr  load / store request (store has priority)
//   funct3          size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr, wdata     effective byte address, store data
//   read_data       extended load result
//   stall           hold PC and register writes this cycle
//   fault           1-cycle pulse: misaligned access or illegal funct3
//   bus_err         1-cycle pulse in DONE after a bus timeout
//   bus_req/we/addr/wstrb/wdata   request side of the memory bus
//   bus_ack, bus_rdata            completion side of the memory bus

// One byte lane of the store path: strobe and write byte for lane LANE.
module lsu_bus_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0]  size,
  input  logic [1:0]  lo,
  input  logic [31:0] wdata,
  output logic        strb,
  output logic [7:0]  wbyte
);
  localparam logic [1:0] LI = 2'(LANE);

  always_comb begin
    strb  = 1'b0;
    wbyte = wdata[7:0];
    case (size)
      2'b00: strb = (lo == LI);
      2'b01: begin
        strb  = (lo[1] == LI[1]);
        wbyte = LI[0] ? wdata[15:8] : wdata[7:0];
      end
      default: begin
        strb  = 1'b1;
        wbyte = wdata[8*LANE +: 8];
      end
    endcase
  end
endmodule

module lsu_bus_if #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        fault,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } breq_t;

  state_t     state, state_nx;
  breq_t      req_q, req_d;
  logic [2:0] f3_q;
  logic [1:0] lo_q;
  logic [CNT_W-1:0] cnt;
  logic [31:0] rd_q;
  logic        err_q;

  // ---------------- request decode (IDLE, combinational) ----------------
  logic [1:0] size;
  logic       access, legal_f3, aligned, legal, go, bad, timeout;

  assign size   = funct3[1:0];
  assign access = mem_rd | mem_wr;

  // Stores: only 000/001/010. Loads: additionally 100/101.
  always_comb begin
    if (mem_wr) legal_f3 = !funct3[2] && (size != 2'b11);
    else        legal_f3 = (size != 2'b11) && !(funct3[2] && size == 2'b10);
  end

  assign aligned = (size == 2'b00) ||
                   (size == 2'b01 && !addr[0]) ||
                   (size == 2'b10 && addr[1:0] == 2'b00);
  assign legal   = legal_f3 && aligned;
  assign go      = (state == IDLE) && access && legal;
  assign bad     = (state == IDLE) && access && !legal;
  assign timeout = (cnt == CNT_W'(TIMEOUT - 1));

  // ---------------- store lanes ----------------
  logic [NUM_LANES-1:0]      lane_strb;
  logic [NUM_LANES-1:0][7:0] lane_byte;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      lsu_bus_lane #(.LANE(gi)) u_lane (
        .size  (size),
        .lo    (addr[1:0]),
        .wdata (wdata),
        .strb  (lane_strb[gi]),
        .wbyte (lane_byte[gi])
      );
    end
  endgenerate

  always_comb begin
    req_d.we    = mem_wr;
    req_d.addr  = {addr[31:2], 2'b00};
    req_d.strb  = mem_wr ? lane_strb : 4'b0000;
    req_d.wdata = lane_byte;
  end

  // ---------------- load extension ----------------
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] ext;

  always_comb begin
    case (lo_q)
      2'd0:    rbyte = bus_rdata[7:0];
      2'd1:    rbyte = bus_rdata[15:8];
      2'd2:    rbyte = bus_rdata[23:16];
      default: rbyte = bus_rdata[31:24];
    endcase
    rhalf = lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (f3_q)
      3'b000:  ext = {{24{rbyte[7]}}, rbyte};
      3'b001:  ext = {{16{rhalf[15]}}, rhalf};
      3'b100:  ext = {24'b0, rbyte};
      3'b101:  ext = {16'b0, rhalf};
      default: ext = bus_rdata;
    endcase
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (go) state_nx = BUS;
      BUS:     if (bus_ack || timeout) state_nx = DONE;
      DONE:    state_nx = IDLE;  // inputs ignored: no reissue of same instr
      default: state_nx = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // rst gating keeps the combinational outputs quiet while reset is held,
  // even if the core is presenting a request.
  always_comb begin
    bus_req   = (state == BUS);
    stall     = rst && (go || state == BUS);
    fault     = rst && bad;
    bus_err   = (state == DONE) && err_q;
    read_data = fault ? 32'h0 : rd_q;
  end

  assign bus_we    = req_q.we;
  assign bus_addr  = req_q.addr;
  assign bus_wstrb = req_q.strb;
  assign bus_wdata = req_q.wdata;

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q <= '0;
      f3_q  <= 3'b0;
      lo_q  <= 2'b0;
      cnt   <= '0;
      rd_q  <= 32'h0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            req_q <= req_d;
            f3_q  <= funct3;
            lo_q  <= addr[1:0];
            cnt   <= '0;
            err_q <= 1'b0;
          end else if (bad) begin
            rd_q  <= 32'h0;
          end
        end
        BUS: begin
          cnt <= cnt + CNT_W'(1);
          // ack wins over a timeout landing on the same cycle
          if (bus_ack) begin
            if (!req_q.we) rd_q <= ext;
          end else if (timeout) begin
            rd_q  <= 32'h0;
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_bus_if.sv
module tb_lsu_bus_if;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_rd = 1'b0, mem_wr = 1'b0;
  logic [2:0]  funct3 = 3'b0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic [31:0] read_data;
  logic        stall, fault, bus_err, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  lsu_bus_if #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_wr(mem_wr), .funct3(funct3),
    .addr(addr), .wdata(wdata), .read_data(read_data), .stall(stall),
    .fault(fault), .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } bexp_t;

  typedef struct {
    bit          is_fault;
    logic [31:0] rd;
    logic        err;
    int          stall;
  } rexp_t;

  bexp_t bq[$];
  rexp_t rq[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int  scnt = 0;
  bit  sprev = 0, rprev = 0;
  always @(negedge clk) begin
    bexp_t b;
    rexp_t r;
    if (!rst) begin
      scnt = 0; sprev = 0; rprev = 0;
    end else begin
      if (bus_req && !rprev) begin
        if (bq.size() == 0) chk("unexpected_bus_req", 32'd1, 32'd0);
        else begin
          b = bq.pop_front();
          chk("bus_we", {31'b0, bus_we}, {31'b0, b.we});
          chk("bus_addr", bus_addr, b.addr);
          chk("bus_wstrb", {28'b0, bus_wstrb}, {28'b0, b.strb});
          if (b.we) chk("bus_wdata", bus_wdata, b.wdata);
        end
      end
      if (fault) begin
        if (rq.size() == 0) chk("unexpected_fault", 32'd1, 32'd0);
        else begin
          r = rq.pop_front();
          chk("fault_kind", {31'b0, r.is_fault}, 32'd1);
          chk("fault_stall", {31'b0, stall}, 32'd0);
          chk("fault_bus_req", {31'b0, bus_req}, 32'd0);
          chk("fault_read_data", read_data, 32'h0);
        end
      end
      if (stall) scnt++;
      else if (sprev) begin
        if (rq.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          r = rq.pop_front();
          chk("done_kind", {31'b0, r.is_fault}, 32'd0);
          chk("read_data", read_data, r.rd);
          chk("bus_err", {31'b0, bus_err}, {31'b0, r.err});
          chk("bus_req_in_done", {31'b0, bus_req}, 32'd0);
          chk("stall_cycles", scnt, r.stall);
        end
        scnt = 0;
      end else if (bus_err) chk("unexpected_bus_err", 32'd1, 32'd0);
      sprev = stall;
      rprev = bus_req;
    end
  end

  // ---------------- driver ----------------
  // n<0: illegal (fault expected); n==0: no ack (timeout); n>0: ack in BUS cycle n.
  task automatic op(input bit rd, input bit wr, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] wd, input int n,
                    input logic [31:0] rdat, input logic [3:0] e_strb,
                    input logic [31:0] e_wdata, input logic [31:0] e_rd);
    bexp_t b;
    rexp_t r;
    if (n < 0) begin
      r.is_fault = 1; r.rd = 32'h0; r.err = 0; r.stall = 0;
      rq.push_back(r);
    end else begin
      b.we = wr; b.addr = {a[31:2], 2'b00}; b.strb = e_strb; b.wdata = e_wdata;
      bq.push_back(b);
      r.is_fault = 0; r.rd = e_rd; r.err = (n == 0);
      r.stall = (n == 0) ? TIMEOUT + 1 : n + 1;
      rq.push_back(r);
    end
    mem_rd = rd; mem_wr = wr; funct3 = f3; addr = a; wdata = wd;
    @(posedge clk); #2;
    mem_rd = 0; mem_wr = 0;
    if (n < 0) begin
      @(posedge clk); #2;
    end else if (n == 0) begin
      repeat (TIMEOUT + 1) @(posedge clk);
      #2;
    end else begin
      repeat (n - 1) @(posedge clk);
      #2;
      bus_ack = 1; bus_rdata = rdat;
      @(posedge clk); #2;
      bus_ack = 0; bus_rdata = 32'h0;
      @(posedge clk); #2;
    end
  endtask

  initial begin
    bexp_t b;
    #3;
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_bus_req", {31'b0, bus_req}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_wstrb", {28'b0, bus_wstrb}, 32'h0);
    chk("rst_read_data", read_data, 32'h0);
    chk("rst_bus_err", {31'b0, bus_err}, 32'd0);
    @(posedge clk); @(posedge clk); #3; rst = 1;
    @(posedge clk); #2;

    //  rd wr f3     addr          wdata         n   rdata         strb     e_wdata       e_rd
    op(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 1, 32'h0,        4'b1111, 32'hDEADBEEF, 32'h0);
    op(0, 1, 3'b000, 32'h103, 32'h000000A5, 1, 32'h0,        4'b1000, 32'hA5A5A5A5, 32'h0);
    op(1, 0, 3'b000, 32'h103, 32'h0,        1, 32'h80FF7F01, 4'b0000, 32'h0,        32'hFFFFFF80);
    op(1, 0, 3'b100, 32'h103, 32'h0,        1, 32'h80FF7F01, 4'b0000, 32'h0,        32'h00000080);
    op(1, 0, 3'b000, 32'h101, 32'h0,        2, 32'h80FF7F01, 4'b0000, 32'h0,        32'h0000007F);
    op(1, 0, 3'b001, 32'h102, 32'h0,        3, 32'h80010000, 4'b0000, 32'h0,        32'hFFFF8001);
    op(1, 0, 3'b101, 32'h102, 32'h0,        3, 32'h80010000, 4'b0000, 32'h0,        32'h00008001);
    op(1, 0, 3'b001, 32'h100, 32'h0,        1, 32'h80FF7F01, 4'b0000, 32'h0,        32'h00007F01);
    op(1, 0, 3'b010, 32'h101, 32'h0,       -1, 32'h0,        4'b0000, 32'h0,        32'h0);
    op(1, 0, 3'b010, 32'h108, 32'h0,        2, 32'h12345678, 4'b0000, 32'h0,        32'h12345678);
    op(1, 0, 3'b011, 32'h100, 32'h0,       -1, 32'h0,        4'b0000, 32'h0,        32'h0);
    op(1, 0, 3'b010, 32'h104, 32'h0,        1, 32'h9ABCDEF0, 4'b0000, 32'h0,        32'h9ABCDEF0);
    op(0, 1, 3'b001, 32'h001, 32'h0,       -1, 32'h0,        4'b0000, 32'h0,        32'h0);
    op(1, 0, 3'b010, 32'h108, 32'h0,        2, 32'h11223344, 4'b0000, 32'h0,        32'h11223344);
    op(1, 0, 3'b010, 32'h104, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0);
    op(1, 0, 3'b010, 32'h10C, 32'h0,       16, 32'hCAFEF00D, 4'b0000, 32'h0,        32'hCAFEF00D);
    op(0, 1, 3'b001, 32'h106, 32'h1234BEEF, 2, 32'h0,        4'b1100, 32'hBEEFBEEF, 32'hCAFEF00D);
    op(1, 1, 3'b010, 32'h110, 32'h55AA55AA, 1, 32'h0,        4'b1111, 32'h55AA55AA, 32'hCAFEF00D);
    op(0, 1, 3'b100, 32'h100, 32'h0,       -1, 32'h0,        4'b0000, 32'h0,        32'h0);

    // reset in the second BUS cycle of a load: pending access discarded
    b.we = 0; b.addr = 32'h200; b.strb = 4'b0000; b.wdata = 32'h0;
    bq.push_back(b);
    mem_rd = 1; funct3 = 3'b010; addr = 32'h200;
    @(posedge clk); #2; mem_rd = 0;
    @(posedge clk); #1;
    rst = 0; #1;
    chk("midrst_bus_req", {31'b0, bus_req}, 32'd0);
    chk("midrst_stall", {31'b0, stall}, 32'd0);
    chk("midrst_bus_addr", bus_addr, 32'h0);
    @(posedge clk); #3; rst = 1;
    @(posedge clk); #2;
    op(0, 1, 3'b010, 32'h120, 32'h0BADF00D, 1, 32'h0,        4'b1111, 32'h0BADF00D, 32'h0);

    repeat (4) @(posedge clk);
    chk("bus_queue_drained", bq.size(), 32'd0);
    chk("resp_queue_drained", rq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end
endmodule
